fpu_mul_issue: RTL and testbench
================================

FPU_MUL_ISSUE -- requirements
Module: fpu_mul_issue

Interface
REQ-001 Parameter DEPTH, default 4, meaning request FIFO entries (power of two, >=2).
REQ-002 Parameter TIMEOUT, default 256, meaning max cycles in WAIT_RES before abort.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  request offered.
REQ-006 req_ready  output  1  request accepted this cycle if req_valid.
REQ-007 req_a, req_b  input  32 each  IEEE-754 single operands.
REQ-008 req_tag  input  4  opaque ID returned with the response.
REQ-009 mul_din1, mul_din2  output  32 each  operands to the multiplier.
REQ-010 mul_valid  output  1  one-cycle launch pulse to the multiplier.
REQ-011 mul_result  input  32  multiplier product.
REQ-012 mul_ready  input  1  one-cycle pulse; mul_result valid in that cycle.
REQ-013 rsp_valid  output  1  response held.
REQ-014 rsp_ready  input  1  consumer accepts the response.
REQ-015 rsp_result  output  32  product.
REQ-016 rsp_tag  output  4  tag of the originating request.
REQ-017 rsp_flags  output  5  {timeout, subnormal, zero, inf, nan}, bit 4..0.
REQ-018 fault  output  1  sticky timeout indicator.

Function
REQ-019 req_ready SHALL be 1 iff FIFO count < DEPTH; no same-cycle pass-through when full.
REQ-020 A push SHALL occur on any edge with req_valid && req_ready, storing {req_a, req_b, req_tag}.
REQ-021 The FSM SHALL have states IDLE, ISSUE, WAIT_RES, HOLD.
REQ-022 IDLE->ISSUE when FIFO non-empty and fault==0: pop head and register it into mul_din1/mul_din2/tag at that edge.
REQ-023 In ISSUE, mul_valid SHALL be 1 for exactly one cycle; next state WAIT_RES; the cycle counter clears.
REQ-024 Push and pop on the same edge SHALL leave count unchanged.
REQ-025 In WAIT_RES, on mul_ready: capture mul_result into rsp_result, compute flags, set rsp_valid, go HOLD.
REQ-026 Flags: nan = exp==255 && man!=0; inf = exp==255 && man==0; zero = exp==0 && man==0; subnormal = exp==0 && man!=0; timeout = 0.
REQ-027 In WAIT_RES, if the counter reaches TIMEOUT-1 without mul_ready: rsp_result=32'hFFC00000, flags=5'b10001, fault<=1, go HOLD.
REQ-028 mul_ready pulses outside WAIT_RES SHALL be ignored.
REQ-029 HOLD: rsp_valid and rsp_* SHALL stay stable until rsp_valid && rsp_ready; on that edge rsp_valid<=0 and state IDLE.
REQ-030 While fault==1, no further issue; FIFO keeps accepting until full.
REQ-031 Responses SHALL be delivered in request order; exactly one multiplication SHALL be in flight at a time.
REQ-032 Minimum latency: push at edge N with the FSM idle and FIFO empty gives pop at N+1, mul_valid high in cycle N+1..N+2, and rsp_valid one edge after the mul_ready pulse.

Reset
REQ-033 While reset==0, state SHALL be IDLE, FIFO empty, counter 0, and all outputs 0: mul_valid, rsp_valid, rsp_result, rsp_tag, rsp_flags, fault, mul_din1, mul_din2.
REQ-034 Reset mid-operation SHALL discard FIFO contents and the in-flight operation without producing a response.
REQ-035 Integration SHALL reset the multiplier in the same cycles; it uses active-high reset, so it is driven with the inversion of reset.

Structure
REQ-036 Package fpu_pkg SHALL hold: the issue FSM state enum, flag bit index constants, FP_QNAN = 32'hFFC00000, and FP_EXP_MAX = 8'hFF.
REQ-037 The FIFO SHALL be sub-module fpu_req_fifo (synchronous, width 68, parameter DEPTH, count output); classification stays inline.

Verification
REQ-038 Scenario: a=0x40000000, b=0x40400000, tag=5 -> rsp_result=0x40C00000, rsp_tag=5, flags=0.
REQ-039 Scenario: a=0x7F800000, b=0x00000000 -> rsp_result=0xFFC00000, flags=5'b00001.
REQ-040 Scenario: a=0x00800000, b=0x3F000000 -> rsp_result=0x00400000, flags=5'b01000.
REQ-041 Scenario: rsp_ready=0, push 6 requests back-to-back -> 1 issued, 4 queued, req_ready low from the 5th accept on; after rsp_ready=1, 5 responses arrive in tag order.
REQ-042 Scenario: mul_ready tied 0 -> after 256 WAIT_RES cycles rsp_result=0xFFC00000, flags=5'b10001, fault=1, no further mul_valid.
REQ-043 Scenario: reset asserted in WAIT_RES with 2 queued -> all outputs 0; after release, no response until a new request is pushed.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared definitions for the FP multiply issue block: FSM state encoding,
// response flag bit positions, the request record carried through the FIFO,
// and the IEEE-754 single-precision constants used for classification.
package fpu_pkg;

  // Issue sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_RES = 2'd2,
    ST_HOLD     = 2'd3
  } issue_state_t;

  // Bit positions inside rsp_flags = {timeout, subnormal, zero, inf, nan}.
  localparam int FLAG_NAN  = 0;
  localparam int FLAG_INF  = 1;
  localparam int FLAG_ZERO = 2;
  localparam int FLAG_SUB  = 3;
  localparam int FLAG_TMO  = 4;

  localparam logic [31:0] FP_QNAN    = 32'hFFC00000;
  localparam logic [7:0]  FP_EXP_MAX = 8'hFF;

  // Queued request: 32 + 32 + 4 = 68 bits.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
  } mul_req_t;

endpackage

// File: rtl/fpu_req_fifo.sv
// Request FIFO: single-clock circular buffer of DEPTH entries (power of two).
// Latency: head visible combinationally; a push is visible one edge later.
// Backpressure: push ignored when full, pop ignored when empty.
// Ports:
//   clk, reset (async, active-low)
//   i_push/i_dat  write side
//   i_pop/o_dat   read side (o_dat is the current head)
//   o_count       number of valid entries, 0..DEPTH
module fpu_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 68
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_dat,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_dat,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic w_do_push;
  logic w_do_pop;

  assign w_do_push = i_push && (r_count != DEPTH_CNT);
  assign w_do_pop  = i_pop  && (r_count != '0);

  assign o_dat   = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Storage needs no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_dat;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fpu_mul_issue.sv
// Issue stage for an external FP multiplier: queues requests, launches one
// multiply at a time, classifies the product and holds it until consumed.
// Latency: push to mul_valid is one edge; rsp_valid rises one edge after mul_ready.
// Backpressure: req_ready drops when the FIFO is full; rsp_* hold until rsp_ready.
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_ready/req_a/req_b/req_tag   request input
//   mul_din1/mul_din2/mul_valid               multiplier launch
//   mul_result/mul_ready                      multiplier return pulse
//   rsp_valid/rsp_ready/rsp_result/rsp_tag/rsp_flags  response output
//   fault                                     sticky timeout indicator
module fpu_mul_issue
  import fpu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [3:0]  req_tag,
  output logic [31:0] mul_din1,
  output logic [31:0] mul_din2,
  output logic        mul_valid,
  input  logic [31:0] mul_result,
  input  logic        mul_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [3:0]  rsp_tag,
  output logic [4:0]  rsp_flags,
  output logic        fault
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT - 1);
  // Aborted operation reports {timeout, nan}.
  localparam logic [4:0]    FLAGS_TMO = 5'b10001;

  issue_state_t  r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_mul_din1;
  logic [31:0]   r_mul_din2;
  logic          r_mul_valid;
  logic [3:0]    r_tag;
  logic          r_rsp_valid;
  logic [31:0]   r_rsp_result;
  logic [3:0]    r_rsp_tag;
  logic [4:0]    r_rsp_flags;
  logic          r_fault;

  logic [AW:0]   w_count;
  logic          w_push;
  logic          w_pop;
  mul_req_t      w_head;
  mul_req_t      w_in;

  // Sign bit plays no part in classification.
  function automatic logic [4:0] classify(input logic [30:0] v);
    logic [7:0]  e;
    logic [22:0] m;
    logic [4:0]  f;
    e = v[30:23];
    m = v[22:0];
    f = '0;
    f[FLAG_NAN]  = (e == FP_EXP_MAX) && (m != '0);
    f[FLAG_INF]  = (e == FP_EXP_MAX) && (m == '0);
    f[FLAG_ZERO] = (e == '0) && (m == '0);
    f[FLAG_SUB]  = (e == '0) && (m != '0);
    return f;
  endfunction

  // Full is judged on the registered count only, so a pop in the same
  // cycle never lets a request slip into a full queue.
  assign req_ready = (w_count < DEPTH_CNT);
  assign w_push    = req_valid && req_ready;
  assign w_pop     = (r_state == ST_IDLE) && (w_count != '0) && !r_fault;

  assign w_in.a   = req_a;
  assign w_in.b   = req_b;
  assign w_in.tag = req_tag;

  fpu_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(mul_req_t))
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_dat   (w_in),
    .i_pop   (w_pop),
    .o_dat   (w_head),
    .o_count (w_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_mul_din1   <= '0;
      r_mul_din2   <= '0;
      r_mul_valid  <= 1'b0;
      r_tag        <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_tag    <= '0;
      r_rsp_flags  <= '0;
      r_fault      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_mul_din1  <= w_head.a;
            r_mul_din2  <= w_head.b;
            r_tag       <= w_head.tag;
            r_mul_valid <= 1'b1;
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_mul_valid <= 1'b0;
          r_cnt       <= '0;
          r_state     <= ST_WAIT_RES;
        end
        ST_WAIT_RES: begin
          // A result arriving on the last allowed cycle still wins.
          if (mul_ready) begin
            r_rsp_result <= mul_result;
            r_rsp_flags  <= classify(mul_result[30:0]);
            r_rsp_tag    <= r_tag;
            r_rsp_valid  <= 1'b1;
            r_state      <= ST_HOLD;
          end else if (r_cnt == CNT_LAST) begin
            r_rsp_result <= FP_QNAN;
            r_rsp_flags  <= FLAGS_TMO;
            r_rsp_tag    <= r_tag;
            r_rsp_valid  <= 1'b1;
            r_fault      <= 1'b1;
            r_state      <= ST_HOLD;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_HOLD: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mul_din1   = r_mul_din1;
  assign mul_din2   = r_mul_din2;
  assign mul_valid  = r_mul_valid;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_tag    = r_rsp_tag;
  assign rsp_flags  = r_rsp_flags;
  assign fault      = r_fault;

endmodule

// File: tb/tb_fpu_mul_issue.sv
// Bench for fpu_mul_issue: a behavioural multiplier returns preloaded
// products one cycle after each launch; directed vectors and hand sequences
// cover classification, backpressure, timeout and reset.
module tb_fpu_mul_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_tag;
  logic [31:0] mul_din1;
  logic [31:0] mul_din2;
  logic        mul_valid;
  logic [31:0] mul_result;
  logic        mul_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_tag;
  logic [4:0]  rsp_flags;
  logic        fault;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fpu_mul_issue #(.DEPTH(4), .TIMEOUT(256)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_tag    (req_tag),
    .mul_din1   (mul_din1),
    .mul_din2   (mul_din2),
    .mul_valid  (mul_valid),
    .mul_result (mul_result),
    .mul_ready  (mul_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_tag    (rsp_tag),
    .rsp_flags  (rsp_flags),
    .fault      (fault)
  );

  // Multiplier model: products come from res_tab in launch order.
  logic [31:0] res_tab [64];
  logic [31:0] m_res;
  int  n_issue    = 0;
  int  m_cnt      = 0;
  int  stray_req  = 0;
  int  stray_done = 0;
  bit  mock_en    = 1'b1;

  always @(negedge clk) begin
    mul_ready = 1'b0;
    if (!reset) begin
      m_cnt      = 0;
      mul_result = 32'h0;
    end else begin
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          mul_ready  = 1'b1;
          mul_result = m_res;
        end
      end else if (stray_req != stray_done) begin
        stray_done++;
        mul_ready  = 1'b1;
        mul_result = 32'h12345678;
      end
      if (mul_valid) begin
        if (mock_en) begin
          m_res = res_tab[n_issue % 64];
          m_cnt = 1;
        end
        n_issue++;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic push1(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
    int k;
    req_a = a; req_b = b; req_tag = tag; req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) chk("push_ready_timeout", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 600) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) chk("rsp_wait_timeout", 32'(rsp_valid), 32'd1);
  endtask

  task automatic accept();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_drop", 32'(rsp_valid), 32'd0);
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_mul_valid"},  32'(mul_valid),  32'd0);
    chk({p, "_rsp_valid"},  32'(rsp_valid),  32'd0);
    chk({p, "_rsp_result"}, rsp_result,      32'd0);
    chk({p, "_rsp_tag"},    32'(rsp_tag),    32'd0);
    chk({p, "_rsp_flags"},  32'(rsp_flags),  32'd0);
    chk({p, "_fault"},      32'(fault),      32'd0);
    chk({p, "_din1"},       mul_din1,        32'd0);
    chk({p, "_din2"},       mul_din2,        32'd0);
    chk({p, "_req_ready"},  32'(req_ready),  32'd1);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] prod;
    logic [4:0]  flags;
  } vec_t;

  vec_t vt [8];

  initial begin
    int lat;
    int base;
    int k;
    int got;
    logic rdy;

    vt[0] = '{32'h40000000, 32'h40400000, 4'd5, 32'h40C00000, 5'b00000};
    vt[1] = '{32'h7F800000, 32'h00000000, 4'd1, 32'hFFC00000, 5'b00001};
    vt[2] = '{32'h00800000, 32'h3F000000, 4'd2, 32'h00400000, 5'b01000};
    vt[3] = '{32'h7F800000, 32'h3F800000, 4'd3, 32'h7F800000, 5'b00010};
    vt[4] = '{32'h80000000, 32'h3F800000, 4'd4, 32'h80000000, 5'b00100};
    vt[5] = '{32'h3F800000, 32'hBF800000, 4'd6, 32'hBF800000, 5'b00000};
    vt[6] = '{32'h7FC00000, 32'h3F800000, 4'd14, 32'h7FC00000, 5'b00001};
    vt[7] = '{32'h807FFFFF, 32'h3F800000, 4'd15, 32'h807FFFFF, 5'b01000};
    for (int i = 0; i < 64; i++) res_tab[i] = 32'h0;

    reset = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_tag = '0;
    rsp_ready = 1'b0;
    cyc(3);
    chk_zero("reset");
    reset = 1'b1;
    cyc(2);

    // Directed vectors, FSM idle and FIFO empty before each.
    for (int i = 0; i < 8; i++) begin
      res_tab[n_issue % 64] = vt[i].prod;
      push1(vt[i].a, vt[i].b, vt[i].tag);
      chk("vec_mv_early", 32'(mul_valid), 32'd0);
      @(negedge clk);
      chk("vec_mv_pulse", 32'(mul_valid), 32'd1);
      chk("vec_din1", mul_din1, vt[i].a);
      chk("vec_din2", mul_din2, vt[i].b);
      wait_rsp(lat);
      chk("vec_latency", 32'(lat), 32'd2);
      chk("vec_result", rsp_result, vt[i].prod);
      chk("vec_tag", 32'(rsp_tag), 32'(vt[i].tag));
      chk("vec_flags", 32'(rsp_flags), 32'(vt[i].flags));
      @(negedge clk);
      chk("vec_hold_valid", 32'(rsp_valid), 32'd1);
      chk("vec_hold_result", rsp_result, vt[i].prod);
      accept();
    end

    // Stray mul_ready while idle, then while holding a response.
    base = n_issue;
    stray_req++;
    cyc(3);
    chk("stray_idle_valid", 32'(rsp_valid), 32'd0);
    chk("stray_idle_issue", 32'(n_issue - base), 32'd0);
    res_tab[n_issue % 64] = 32'h40000000;
    push1(32'h3F800000, 32'h40000000, 4'd9);
    wait_rsp(lat);
    stray_req++;
    cyc(3);
    chk("stray_hold_valid", 32'(rsp_valid), 32'd1);
    chk("stray_hold_result", rsp_result, 32'h40000000);
    chk("stray_hold_tag", 32'(rsp_tag), 32'd9);
    accept();

    // Backpressure: six offered back-to-back with responses blocked.
    base = n_issue;
    for (int i = 0; i < 6; i++) res_tab[(base + i) % 64] = 32'h41000000 + 32'(i);
    k = 0;
    for (int c = 0; c < 20 && k < 6; c++) begin
      req_a = 32'h3F800000 + 32'(k); req_b = 32'h40000000;
      req_tag = 4'(8 + k); req_valid = 1'b1;
      rdy = req_ready;
      @(negedge clk);
      if (rdy) k++;
    end
    req_valid = 1'b0;
    chk("bp_accepts", 32'(k), 32'd5);
    chk("bp_req_ready", 32'(req_ready), 32'd0);
    chk("bp_issued", 32'(n_issue - base), 32'd1);
    chk("bp_hold_tag", 32'(rsp_tag), 32'd8);
    rsp_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 100 && got < 5; c++) begin
      if (rsp_valid) begin
        chk("bp_order_tag", 32'(rsp_tag), 32'(8 + got));
        chk("bp_order_result", rsp_result, 32'h41000000 + 32'(got));
        got++;
      end
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    chk("bp_rsp_count", 32'(got), 32'd5);

    // Timeout: multiplier never answers; a second request waits behind.
    mock_en = 1'b0;
    base = n_issue;
    push1(32'h40000000, 32'h40000000, 4'd7);
    push1(32'h40400000, 32'h40000000, 4'd10);
    chk("tmo_mv", 32'(mul_valid), 32'd1);
    lat = 0;
    while (!rsp_valid && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    chk("tmo_cycles", 32'(lat), 32'd257);
    chk("tmo_result", rsp_result, 32'hFFC00000);
    chk("tmo_flags", 32'(rsp_flags), 32'h11);
    chk("tmo_tag", 32'(rsp_tag), 32'd7);
    chk("tmo_fault", 32'(fault), 32'd1);
    accept();
    cyc(20);
    chk("tmo_no_issue", 32'(n_issue - base), 32'd1);
    chk("tmo_no_rsp", 32'(rsp_valid), 32'd0);
    k = 0;
    for (int c = 0; c < 10; c++) begin
      req_a = 32'h3F800000; req_b = 32'h3F800000; req_tag = 4'(k); req_valid = 1'b1;
      rdy = req_ready;
      @(negedge clk);
      if (rdy) k++;
    end
    req_valid = 1'b0;
    chk("tmo_fill_accepts", 32'(k), 32'd3);
    chk("tmo_fill_ready", 32'(req_ready), 32'd0);
    chk("tmo_fault_sticky", 32'(fault), 32'd1);

    // Reset clears the fault state.
    reset = 1'b0;
    #1;
    chk_zero("rst_fault");
    cyc(2);
    reset = 1'b1;
    cyc(1);

    // Reset while waiting on the multiplier with two queued.
    base = n_issue;
    push1(32'h40000000, 32'h40000000, 4'd1);
    push1(32'h40000000, 32'h40400000, 4'd2);
    push1(32'h40400000, 32'h40400000, 4'd3);
    cyc(5);
    chk("rst_wait_issued", 32'(n_issue - base), 32'd1);
    reset = 1'b0;
    #1;
    chk_zero("rst_mid");
    cyc(2);
    reset = 1'b1;
    mock_en = 1'b1;
    base = n_issue;
    cyc(30);
    chk("rst_no_issue", 32'(n_issue - base), 32'd0);
    chk("rst_no_rsp", 32'(rsp_valid), 32'd0);
    res_tab[n_issue % 64] = 32'h40C00000;
    push1(32'h40000000, 32'h40400000, 4'd11);
    wait_rsp(lat);
    chk("rst_after_tag", 32'(rsp_tag), 32'd11);
    chk("rst_after_result", rsp_result, 32'h40C00000);
    chk("rst_after_flags", 32'(rsp_flags), 32'd0);
    accept();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
